ifft_manager: RTL and testbench

IFFT_MANAGER -- requirements
Module: ifft_manager

---
 rtl/ifft_manager.sv | 162 ++++++++++++++++
 tb/tb_ifft_manager.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_manager.sv
// 16-point inverse DFT on an AXI-Stream frame, streamed out with a cyclic prefix.
// Latency: 257 cycles from the 16th input accept to the first output valid (one complex MAC per cycle).
// Backpressure: input is refused outside LOAD; the output register holds while m_axis_data_tready is low.
module ifft_manager #(
  parameter int CP_LEN = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_data_tdata,
  input  logic        s_axis_data_tvalid,
  input  logic        s_axis_data_tlast,
  output logic        s_axis_data_tready,
  output logic [31:0] m_axis_data_tdata,
  output logic [7:0]  m_axis_data_tuser,
  output logic        m_axis_data_tvalid,
  output logic        m_axis_data_tlast,
  input  logic        m_axis_data_tready,
  output logic [15:0] m_axis_real_unsigned
);

  typedef struct packed {
    logic signed [15:0] im;
    logic signed [15:0] re;
  } cplx_t;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  localparam int OUT_LEN = 16 + CP_LEN;

  state_t state, state_nxt;
  cplx_t  x_buf [16];
  cplx_t  y_buf [16];
  cplx_t  xk;

  logic [3:0] in_cnt, k_idx, n_idx, tw_idx, ld_n;
  logic [4:0] out_cnt, ld_cnt;
  logic signed [15:0] wc, ws;
  logic signed [31:0] p_rc, p_is, p_rs, p_ic;
  logic signed [39:0] acc_re, acc_im, sum_re, sum_im;
  logic accept, xfer, out_last, mac_done, load_out;
  logic unused_tlast;

  assign unused_tlast = s_axis_data_tlast;

  // Quarter-wave cosine table in Q2.14; sine is the same table rotated by -4.
  function automatic logic signed [15:0] cos_q14(input logic [3:0] m);
    case (m)
      4'd0:    cos_q14 = 16'sd16384;
      4'd1,  4'd15: cos_q14 = 16'sd15137;
      4'd2,  4'd14: cos_q14 = 16'sd11585;
      4'd3,  4'd13: cos_q14 = 16'sd6270;
      4'd5,  4'd11: cos_q14 = -16'sd6270;
      4'd6,  4'd10: cos_q14 = -16'sd11585;
      4'd7,  4'd9:  cos_q14 = -16'sd15137;
      4'd8:    cos_q14 = -16'sd16384;
      default: cos_q14 = 16'sd0;
    endcase
  endfunction

  function automatic logic [15:0] sat16(input logic signed [39:0] v);
    if (v > 40'sd32767)       sat16 = 16'h7FFF;
    else if (v < -40'sd32768) sat16 = 16'h8000;
    else                      sat16 = v[15:0];
  endfunction

  // Output slot c maps to time index: prefix slots first, then the body.
  function automatic logic [3:0] out_n(input logic [4:0] c);
    int oc;
    int nv;
    oc = int'(c);
    nv = (oc < CP_LEN) ? (oc + 16 - CP_LEN) : (oc - CP_LEN);
    out_n = 4'(nv);
  endfunction

  always_comb begin
    accept   = s_axis_data_tvalid && s_axis_data_tready && (state == LOAD);
    xfer     = m_axis_data_tvalid && m_axis_data_tready;
    out_last = (out_cnt == 5'(OUT_LEN - 1));
    mac_done = (k_idx == 4'd15) && (n_idx == 4'd15);
    ld_cnt   = m_axis_data_tvalid ? (out_cnt + 5'd1) : out_cnt;
    ld_n     = out_n(ld_cnt);
    load_out = (state == OUTPUT) && (!m_axis_data_tvalid || (xfer && !out_last));
  end

  always_comb begin
    xk     = x_buf[k_idx];
    tw_idx = k_idx * n_idx;
    wc     = cos_q14(tw_idx);
    ws     = cos_q14(tw_idx + 4'd12);
    p_rc   = xk.re * wc;
    p_is   = xk.im * ws;
    p_rs   = xk.re * ws;
    p_ic   = xk.im * wc;
    sum_re = acc_re + 40'(p_rc) - 40'(p_is);
    sum_im = acc_im + 40'(p_rs) + 40'(p_ic);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && in_cnt == 4'd15) state_nxt = COMPUTE;
      COMPUTE: if (mac_done) state_nxt = OUTPUT;
      OUTPUT:  if (xfer && out_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= LOAD;
    else          state <= state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (accept) x_buf[in_cnt] <= s_axis_data_tdata;
    if (state == COMPUTE && k_idx == 4'd15)
      y_buf[n_idx] <= {sat16(sum_im >>> 18), sat16(sum_re >>> 18)};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axis_data_tready   <= 1'b0;
      in_cnt               <= '0;
      k_idx                <= '0;
      n_idx                <= '0;
      out_cnt              <= '0;
      acc_re               <= '0;
      acc_im               <= '0;
      m_axis_data_tdata    <= '0;
      m_axis_data_tuser    <= '0;
      m_axis_data_tvalid   <= 1'b0;
      m_axis_data_tlast    <= 1'b0;
      m_axis_real_unsigned <= '0;
    end else begin
      s_axis_data_tready <= (state_nxt == LOAD);
      if (accept) in_cnt <= in_cnt + 4'd1;
      if (state == COMPUTE) begin
        k_idx <= k_idx + 4'd1;
        if (k_idx == 4'd15) begin
          acc_re <= '0;
          acc_im <= '0;
          n_idx  <= n_idx + 4'd1;
        end else begin
          acc_re <= sum_re;
          acc_im <= sum_im;
        end
      end
      if (load_out) begin
        out_cnt              <= ld_cnt;
        m_axis_data_tdata    <= y_buf[ld_n];
        m_axis_data_tuser    <= {4'd0, ld_n};
        m_axis_data_tlast    <= (ld_cnt == 5'(OUT_LEN - 1));
        m_axis_real_unsigned <= y_buf[ld_n].re ^ 16'h8000;
        m_axis_data_tvalid   <= 1'b1;
      end else if (state == OUTPUT && xfer && out_last) begin
        out_cnt            <= '0;
        m_axis_data_tvalid <= 1'b0;
        m_axis_data_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifft_manager.sv
// Directed + randomized bench for ifft_manager against a direct-DFT reference model.
module tb_ifft_manager;

  localparam int    CP   = 4;
  localparam int    NOUT = 16 + CP;
  localparam real   PI   = 3.14159265358979;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [31:0] m_tdata;
  logic [7:0]  m_tuser;
  logic        m_tvalid, m_tlast, m_tready;
  logic [15:0] m_real_u;

  int passed = 0;
  int total  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc;
  int lat_a, lat_b, lat_x;

  int          tw_c [16];
  int          tw_s [16];
  logic [31:0] frame [16];
  logic [31:0] expq  [NOUT];
  logic [31:0] obs   [NOUT];

  ifft_manager #(.CP_LEN(CP)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_data_tdata    (s_tdata),
    .s_axis_data_tvalid   (s_tvalid),
    .s_axis_data_tlast    (s_tlast),
    .s_axis_data_tready   (s_tready),
    .m_axis_data_tdata    (m_tdata),
    .m_axis_data_tuser    (m_tuser),
    .m_axis_data_tvalid   (m_tvalid),
    .m_axis_data_tlast    (m_tlast),
    .m_axis_data_tready   (m_tready),
    .m_axis_real_unsigned (m_real_u)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, o, e);
    end
  endtask

  // Reference: direct inverse DFT with plain integer arithmetic, then cyclic-prefix ordering.
  task automatic compute_expected();
    logic [31:0] y [16];
    for (int n = 0; n < 16; n++) begin
      longint sr = 0;
      longint si = 0;
      for (int k = 0; k < 16; k++) begin
        int m = (k * n) % 16;
        longint a = longint'($signed(frame[k][15:0]));
        longint b = longint'($signed(frame[k][31:16]));
        sr += a * tw_c[m] - b * tw_s[m];
        si += a * tw_s[m] + b * tw_c[m];
      end
      sr = sr >>> 18;
      si = si >>> 18;
      if (sr > 32767) sr = 32767;
      if (sr < -32768) sr = -32768;
      if (si > 32767) si = 32767;
      if (si < -32768) si = -32768;
      y[n] = {si[15:0], sr[15:0]};
    end
    for (int i = 0; i < NOUT; i++)
      expq[i] = (i < CP) ? y[16 - CP + i] : y[i - CP];
  endtask

  task automatic send_frame(input int gap_max, input int nsamp);
    for (int k = 0; k < nsamp; k++) begin
      if (gap_max > 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(0, gap_max)) step();
      end
      s_tvalid = 1'b1;
      s_tdata  = frame[k];
      s_tlast  = (k == 15);
      chk("load_tready", s_tready, 1);
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    acc_cyc  = cyc;
    if (nsamp == 16) chk("tready_after_16th", s_tready, 0);
  endtask

  task automatic collect_frame(input int bp, output int lat);
    int w = 0;
    int i = 0;
    int guard = 0;
    logic rdy_bad = 1'b0;
    m_tready = 1'b1;
    while (!m_tvalid && w < 300) begin
      if (s_tready) rdy_bad = 1'b1;
      step();
      w++;
    end
    lat = cyc - acc_cyc;
    chk("first_valid_seen", m_tvalid, 1);
    chk("latency_le_300", lat <= 300, 1);
    chk("tready_low_compute", rdy_bad, 0);
    while (i < NOUT && guard < 2000) begin
      chk($sformatf("valid[%0d]", i), m_tvalid, 1);
      chk($sformatf("tdata[%0d]", i), m_tdata, expq[i]);
      chk($sformatf("tuser[%0d]", i), m_tuser, (i < CP) ? 16 - CP + i : i - CP);
      chk($sformatf("tlast[%0d]", i), m_tlast, i == NOUT - 1);
      chk($sformatf("real_u[%0d]", i), m_real_u, expq[i][15:0] ^ 16'h8000);
      chk($sformatf("s_tready_out[%0d]", i), s_tready, 0);
      obs[i] = m_tdata;
      m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (m_tready) i++;
      guard++;
    end
    m_tready = 1'b1;
    chk("valid_after_frame", m_tvalid, 0);
    chk("tready_after_frame", s_tready, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_tready", s_tready, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_real_u", m_real_u, 0);
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    step();
    step();
    check_reset_outputs();
    aresetn = 1'b1;
    step();
    chk("release_tready", s_tready, 1);
    chk("release_tvalid", m_tvalid, 0);
  endtask

  task automatic set_dc();
    for (int k = 0; k < 16; k++) frame[k] = (k == 0) ? 32'h0000_7FE0 : 32'h0;
    compute_expected();
  endtask

  task automatic set_random();
    for (int k = 0; k < 16; k++) frame[k] = $urandom;
    compute_expected();
  endtask

  initial begin
    for (int m = 0; m < 16; m++) begin
      tw_c[m] = int'($floor(16384.0 * $cos(2.0 * PI * m / 16.0) + 0.5));
      tw_s[m] = int'($floor(16384.0 * $sin(2.0 * PI * m / 16.0) + 0.5));
    end
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (3) step();
    check_reset_outputs();
    aresetn = 1'b1;
    step();
    chk("first_edge_tready", s_tready, 1);

    // DC frame then the two-tone frame, back to back.
    set_dc();
    send_frame(0, 16);
    collect_frame(0, lat_a);
    for (int i = 0; i < NOUT; i++) chk("dc_value", obs[i], 32'h0000_07FE);

    for (int k = 0; k < 16; k++) frame[k] = 32'h0;
    frame[1]  = 32'h7FE0_7FE0;
    frame[15] = 32'h7FE0_8020;
    compute_expected();
    send_frame(0, 16);
    collect_frame(0, lat_b);
    chk("tone_first_n12", obs[0], 32'hF004_0000);
    chk("tone_n0_im", obs[CP + 0], {16'd4092, 16'd0});
    chk("tone_n1_im", obs[CP + 1], {16'd5346, 16'd0});
    chk("tone_n4_im", obs[CP + 4], {16'd4092, 16'd0});
    chk("equal_latency", lat_a, lat_b);

    // Random frames with input gaps and output backpressure.
    for (int f = 0; f < 3; f++) begin
      set_random();
      send_frame(3, 16);
      collect_frame(1, lat_x);
      chk("rand_latency", lat_x, lat_a);
    end

    // Full-scale frame aimed at n=1 drives the saturation path.
    for (int k = 0; k < 16; k++)
      frame[k] = {(tw_s[(16 - k) % 16] >= 0) ? 16'h7FFF : 16'h8000,
                  (tw_c[k] >= 0) ? 16'h7FFF : 16'h8000};
    compute_expected();
    send_frame(2, 16);
    collect_frame(1, lat_x);

    // Reset mid-LOAD after 7 samples.
    set_random();
    send_frame(0, 7);
    do_reset();
    set_dc();
    send_frame(2, 16);
    collect_frame(1, lat_x);

    // Reset mid-OUTPUT discards the pending frame.
    set_random();
    send_frame(0, 16);
    begin
      int w = 0;
      while (!m_tvalid && w < 300) begin
        step();
        w++;
      end
    end
    chk("midout_valid", m_tvalid, 1);
    repeat (3) step();
    do_reset();
    set_dc();
    send_frame(0, 16);
    collect_frame(0, lat_x);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
